// File: rtl/rt_pkg.sv
// Shared types and defaults for the reaction-timer game-control stage.
package rt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    FALSE = 3'd4
  } state_t;

  localparam int unsigned TICK_DIV_DEF      = 50000;
  localparam int unsigned MIN_DELAY_MS_DEF  = 1000;
  localparam int unsigned RAND_BITS_DEF     = 11;
  localparam int unsigned RT_W_DEF          = 14;
  localparam int unsigned RT_MAX_DEF        = 9999;

  // Number of bits needed to hold max_val (at least 1).
  function automatic int unsigned bits_for(input longint unsigned max_val);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 64; i++) begin
      if ((max_val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1, o_tick high on the last count.
// Synchronous clear restarts the count so a round begins on a fresh ms boundary.
module ms_tick_gen
  import rt_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned PW = bits_for(longint'(TICK_DIV - 1));

  logic [PW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == PW'(TICK_DIV - 1));
  assign o_tick = w_last;

  // Free-running prescaler with wrap and synchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/reaction_timer_fsm.sv
// Reaction-timer game control: random wait, GO light, reaction measurement
// in ms, false-start detection.
// Optional build macro REACTION_TIMEOUT_EN: end the round with a timeout
// once the reaction counter has saturated and another tick elapses.
module reaction_timer_fsm
  import rt_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned MIN_DELAY_MS = MIN_DELAY_MS_DEF,
  parameter int unsigned RAND_BITS    = RAND_BITS_DEF,
  parameter int unsigned RT_W         = RT_W_DEF,
  parameter int unsigned RT_MAX       = RT_MAX_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            btn,
  input  logic [31:0]     rnd_in,
  output logic            led_go,
  output logic            busy,
  output logic            result_valid,
  output logic [RT_W-1:0] reaction_ms,
  output logic            false_start,
  output logic            timeout
);

  // Largest loadable delay; the counter is sized so the sum cannot overflow.
  localparam longint unsigned DLY_MAX = longint'(MIN_DELAY_MS) + (longint'(1) << RAND_BITS) - 1;
  localparam int unsigned     DLY_W   = bits_for(DLY_MAX);

  localparam logic [RT_W-1:0] RT_MAX_V = RT_W'(RT_MAX);

  state_t            r_state;
  logic [DLY_W-1:0]  r_dly_cnt;
  logic [RT_W-1:0]   r_rt_cnt;
  logic [RT_W-1:0]   r_reaction_ms;
  logic              r_led_go;
  logic              r_busy;
  logic              r_result_valid;
  logic              r_false_start;

  logic              w_tick;
  logic              w_start_acc;
  logic [DLY_W-1:0]  w_dly_sum;
  logic [DLY_W-1:0]  w_dly_load;
  logic              w_unused_rnd;

  assign w_start_acc = start && (r_state inside {IDLE, DONE, FALSE});

  // A zero delay would never reach the terminal tick, so it is lifted to 1 ms.
  assign w_dly_sum   = DLY_W'(MIN_DELAY_MS) + DLY_W'(rnd_in[RAND_BITS-1:0]);
  assign w_dly_load  = (w_dly_sum == '0) ? DLY_W'(1) : w_dly_sum;
  assign w_unused_rnd = ^rnd_in;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_start_acc),
    .o_tick  (w_tick)
  );

`ifdef REACTION_TIMEOUT_EN
  logic r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign led_go       = r_led_go;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign reaction_ms  = r_reaction_ms;
  assign false_start  = r_false_start;

  // Round FSM with counters and registered Moore outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_dly_cnt      <= '0;
      r_rt_cnt       <= '0;
      r_reaction_ms  <= '0;
      r_led_go       <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_false_start  <= 1'b0;
`ifdef REACTION_TIMEOUT_EN
      r_timeout      <= 1'b0;
`endif
    end else begin
      r_result_valid <= 1'b0;
      if (w_start_acc) begin
        // Start has priority over a coincident button press.
        r_dly_cnt     <= w_dly_load;
        r_reaction_ms <= '0;
        r_false_start <= 1'b0;
`ifdef REACTION_TIMEOUT_EN
        r_timeout     <= 1'b0;
`endif
        r_state       <= WAIT;
        r_busy        <= 1'b1;
        r_led_go      <= 1'b0;
      end else begin
        case (r_state)
          WAIT: begin
            // An early press beats a coincident terminal tick.
            if (btn) begin
              r_state       <= FALSE;
              r_false_start <= 1'b1;
              r_busy        <= 1'b0;
            end else if (w_tick) begin
              r_dly_cnt <= r_dly_cnt - DLY_W'(1);
              if (r_dly_cnt == DLY_W'(1)) begin
                r_state  <= GO;
                r_led_go <= 1'b1;
                r_rt_cnt <= '0;
              end
            end
          end
          GO: begin
            if (btn) begin
              // Counter value before any coincident tick increment.
              r_reaction_ms  <= r_rt_cnt;
              r_result_valid <= 1'b1;
              r_state        <= DONE;
              r_led_go       <= 1'b0;
              r_busy         <= 1'b0;
            end else if (w_tick) begin
`ifdef REACTION_TIMEOUT_EN
              if (r_rt_cnt >= RT_MAX_V) begin
                r_timeout      <= 1'b1;
                r_reaction_ms  <= RT_MAX_V;
                r_result_valid <= 1'b1;
                r_state        <= DONE;
                r_led_go       <= 1'b0;
                r_busy         <= 1'b0;
              end else begin
                r_rt_cnt <= r_rt_cnt + RT_W'(1);
              end
`else
              if (r_rt_cnt < RT_MAX_V) begin
                r_rt_cnt <= r_rt_cnt + RT_W'(1);
              end
`endif
            end
          end
          default: begin
            // IDLE, DONE, FALSE hold their outputs until the next start.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Scoreboard bench for reaction_timer_fsm with small timing parameters.
module tb_reaction_timer_fsm;

  localparam int TD    = 4;
  localparam int MIN   = 3;
  localparam int RB    = 2;
  localparam int RTW   = 14;
  localparam int RTMAX = 20;
`ifdef REACTION_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           btn = 1'b0;
  logic [31:0]    rnd_in = '0;
  logic           led_go, busy, result_valid, false_start, timeout;
  logic [RTW-1:0] reaction_ms;

  reaction_timer_fsm #(
    .TICK_DIV     (TD),
    .MIN_DELAY_MS (MIN),
    .RAND_BITS    (RB),
    .RT_W         (RTW),
    .RT_MAX       (RTMAX)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .btn          (btn),
    .rnd_in       (rnd_in),
    .led_go       (led_go),
    .busy         (busy),
    .result_valid (result_valid),
    .reaction_ms  (reaction_ms),
    .false_start  (false_start),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_GO = 0, EV_RES = 1, EV_FALSE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    bit       tmo;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int delay_of(input logic [31:0] rnd);
    int d;
    d = MIN + int'(rnd[RB-1:0]);
    if (d == 0) d = 1;
    return d;
  endfunction

  // Monitor: pops an expectation whenever the DUT presents an event.
  initial begin
    ev_t e;
    logic prev_led, prev_fs;
    prev_led = 1'b0;
    prev_fs  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_led = 1'b0;
        prev_fs  = 1'b0;
      end else begin
        if (led_go && !prev_led) begin
          if (sb.size() == 0) check("unexpected_go", 1, 0);
          else begin
            e = sb.pop_front();
            check("go_kind", int'(e.kind), int'(EV_GO));
            check("go_cycle", cyc, e.val);
          end
        end
        if (result_valid) begin
          if (sb.size() == 0) check("unexpected_result", 1, 0);
          else begin
            e = sb.pop_front();
            check("res_kind", int'(e.kind), int'(EV_RES));
            check("res_value", reaction_ms, e.val);
            check("res_timeout", timeout, e.tmo);
          end
        end
        if (false_start && !prev_fs) begin
          if (sb.size() == 0) check("unexpected_false", 1, 0);
          else begin
            e = sb.pop_front();
            check("false_kind", int'(e.kind), int'(EV_FALSE));
          end
        end
        prev_led = led_go;
        prev_fs  = false_start;
      end
    end
  end

  // One round: off = button edge relative to the GO edge (<=0 means early press).
  // xs > 0 issues an extra start xs cycles after the real one (must be ignored).
  task automatic run_round(input logic [31:0] rnd, input int off, input bit btn_with_start, input int xs);
    int  d, g, scyc, bedge, exp_rms;
    bit  tmo_case, exp_fs;
    ev_t e;
    d = delay_of(rnd);
    @(negedge clk);
    scyc     = cyc + 1;
    g        = scyc + d * TD;
    bedge    = g + off;
    tmo_case = TMO_EN && (off > TD * (RTMAX + 1));
    exp_fs   = (off <= 0);
    if (exp_fs) begin
      exp_rms = 0;
      e = '{EV_FALSE, 0, 1'b0}; sb.push_back(e);
    end else begin
      e = '{EV_GO, g, 1'b0}; sb.push_back(e);
      if (tmo_case) exp_rms = RTMAX;
      else begin
        exp_rms = (off - 1) / TD;
        if (exp_rms > RTMAX) exp_rms = RTMAX;
      end
      e = '{EV_RES, exp_rms, tmo_case}; sb.push_back(e);
    end
    start  = 1'b1;
    rnd_in = rnd;
    btn    = btn_with_start;
    @(negedge clk);
    start = 1'b0;
    btn   = 1'b0;
    check("start_busy", busy, 1);
    check("start_led", led_go, 0);
    check("start_fs_clear", false_start, 0);
    check("start_rms_clear", reaction_ms, 0);
    check("start_tmo_clear", timeout, 0);
    while (cyc < bedge - 1) begin
      if (xs > 0 && cyc == scyc + xs - 1) begin
        start  = 1'b1;
        rnd_in = ~rnd;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("prepress_busy", busy, tmo_case ? 0 : 1);
    check("prepress_led", led_go, (tmo_case || off < 1) ? 0 : 1);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    check("end_led", led_go, 0);
    check("end_busy", busy, 0);
    check("end_fs", false_start, exp_fs);
    check("end_rms", reaction_ms, exp_rms);
    check("end_tmo", timeout, tmo_case);
    check("sb_drained", sb.size(), 0);
  endtask

  // Start a round, then pull reset at_rel cycles after the start edge.
  task automatic reset_mid(input logic [31:0] rnd, input int at_rel);
    int  d, scyc;
    ev_t e;
    d = delay_of(rnd);
    @(negedge clk);
    scyc = cyc + 1;
    if (at_rel >= d * TD) begin
      e = '{EV_GO, scyc + d * TD, 1'b0}; sb.push_back(e);
    end
    start  = 1'b1;
    rnd_in = rnd;
    @(negedge clk);
    start = 1'b0;
    while (cyc < scyc + at_rel) @(negedge clk);
    check("prereset_led", led_go, (at_rel >= d * TD) ? 1 : 0);
    check("prereset_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_led", led_go, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_rms", reaction_ms, 0);
    check("rst_fs", false_start, 0);
    check("rst_tmo", timeout, 0);
    sb.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Hard bound on run time.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] r;
    int          off, xs;
    repeat (3) @(negedge clk);
    check("reset_led", led_go, 0);
    check("reset_busy", busy, 0);
    check("reset_rv", result_valid, 0);
    check("reset_rms", reaction_ms, 0);
    check("reset_fs", false_start, 0);
    check("reset_tmo", timeout, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // D=5, press 30 cycles after GO -> 7 ms.
    r = $urandom(); r[1:0] = 2'b10;
    run_round(r, 30, 1'b0, 0);
    // Press 10 cycles after start (still waiting) -> false start.
    r = $urandom(); r[1:0] = 2'b10;
    run_round(r, -10, 1'b0, 0);
    // Press on the tick with counter 4 -> 4 ms; extra start while busy ignored.
    r = $urandom(); r[1:0] = 2'b01;
    run_round(r, 20, 1'b0, 6);
    r = $urandom(); r[1:0] = 2'b11;
    run_round(r, 15, 1'b0, 30);
    // Start and button together from DONE: start wins.
    r = $urandom();
    run_round(r, 9, 1'b1, 0);
    // Press on the terminal wait tick -> false start.
    r = $urandom();
    run_round(r, 0, 1'b0, 0);
    // Start and button together from FALSE.
    r = $urandom();
    run_round(r, 1, 1'b1, 0);
    run_round($urandom(), 4, 1'b0, 0);
    run_round($urandom(), 5, 1'b0, 0);
    // Long hold: saturation (or timeout when enabled).
    run_round($urandom(), 100, 1'b0, 0);

    // Randomised rounds.
    for (int i = 0; i < 10; i++) begin
      r = $urandom();
      if ($urandom_range(0, 3) == 0) off = -int'($urandom_range(0, 11));
      else off = int'($urandom_range(1, 80));
      xs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 10)) : 0;
      if (xs >= delay_of(r) * TD + off) xs = 0;
      run_round(r, off, 1'b0, xs);
    end

    // Reset mid-WAIT and mid-GO, then normal operation.
    r = $urandom(); r[1:0] = 2'b10;
    reset_mid(r, 8);
    run_round($urandom(), 12, 1'b0, 0);
    r = $urandom(); r[1:0] = 2'b00;
    reset_mid(r, 12 + 10);
    run_round($urandom(), 27, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer_fsm.md
Name: reaction_timer_fsm

Overview:
- Game-control stage directly downstream of the 32-bit LFSR random generator; consumes its `rnd_out` word.
- On `start`, converts the random word into a random wait period in milliseconds. It then lights the GO LED and measures the player's reaction time in ms.
- Detects false starts (button pressed before GO). Produces a result for the display/BCD stage.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (CLK_HZ/1000); must be ≥2.
- MIN_DELAY_MS, 1000, fixed minimum wait before GO.
- RAND_BITS, 11, number of low random bits added to the wait (0..2^RAND_BITS-1 ms).
- RT_W, 14, width of reaction counter/result.
- RT_MAX, 9999, saturation value of the reaction counter (4-digit display limit).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse, begin a round (already debounced)
- btn  in  1  single-cycle pulse, player press (already debounced/edge-detected)
- rnd_in  in  32  random word from LFSR generator
- led_go  out  1  GO light
- busy  out  1  high in WAIT or GO
- result_valid  out  1  one-cycle pulse when reaction_ms is updated
- reaction_ms  out  RT_W  measured reaction time, held
- false_start  out  1  level, set on early press, cleared by next accepted start
- timeout  out  1  only with feature; level, else tied 0

Behaviour:
- Reset: state IDLE, all outputs 0, prescaler 0, delay counter 0, reaction counter 0.
- States: IDLE, WAIT, GO, DONE, FALSE. Outputs are Moore/registered: `led_go`=(state==GO), `busy`=(WAIT|GO).
- Tick: the prescaler counts 0..TICK_DIV-1 and wraps. `tick` = (prescaler==TICK_DIV-1). The prescaler is forced to 0 on an accepted start.
- Start accepted in IDLE, DONE, FALSE; ignored in WAIT/GO. On acceptance:
  - delay_cnt <= MIN_DELAY_MS + rnd_in[RAND_BITS-1:0], zero-extended, width sized so the sum never overflows.
  - reaction_ms <= 0, false_start <= 0, timeout <= 0.
  - next state WAIT.
- WAIT:
  - Each tick decrements delay_cnt.
  - A tick with delay_cnt==1 moves to GO at that edge; reaction counter <= 0.
  - GO is therefore entered exactly D*TICK_DIV cycles after the start edge (D = loaded delay).
- WAIT + btn: go to FALSE, false_start <= 1, result_valid stays 0.
  - btn coincident with the terminal tick: false start wins.
- GO:
  - Each tick increments the reaction counter, saturating at RT_MAX (holds, no wrap).
  - btn: reaction_ms <= counter (pre-increment value if a tick coincides); result_valid pulses 1 cycle; next state DONE.
- DONE/FALSE: idle-equivalent; outputs held until the next accepted start.
- start and btn in the same cycle in IDLE/DONE/FALSE: start accepted, btn ignored.
- MIN_DELAY_MS=0 with zero random bits (D=0): treated as D=1 (loaded value forced to minimum 1).
- Asynchronous reset mid-round: immediate return to IDLE, `led_go` drops, no result_valid.

Optional Feature:
- Macro REACTION_TIMEOUT_EN. Defined:
  - When the reaction counter reaches RT_MAX in GO, the next tick moves to DONE.
  - On that transition: timeout <= 1, reaction_ms <= RT_MAX, result_valid pulses once.
- Not defined:
  - GO waits indefinitely with the counter saturated at RT_MAX.
  - timeout is tied to 0.

Decomposition:
- Shared package `rt_pkg`:
  - state enum (IDLE, WAIT, GO, DONE, FALSE) with 3-bit encoding.
  - default constants TICK_DIV_DEF, RT_MAX_DEF, MIN_DELAY_MS_DEF.
- One sub-module, `ms_tick_gen`: prescaler with sync clear, parameter TICK_DIV, output tick. The FSM and counters stay in the top.

Test Plan (TICK_DIV=4, MIN_DELAY_MS=3, RAND_BITS=2, RT_MAX=20):
- rnd_in=32'h...2, start pulse → D=5; led_go rises exactly 20 cycles after start edge; busy high throughout.
- Continuing: btn pulse 30 cycles after GO entry → reaction_ms=7; result_valid high exactly 1 cycle; state DONE; led_go=0.
- Start, btn 10 cycles later (in WAIT) → false_start=1, led_go never rises, result_valid stays 0. Next start clears false_start.
- In GO, btn on same cycle as tick with counter=4 → reaction_ms=4. Start pulse while busy → ignored, delay not reloaded.
- Hold btn off in GO for 100 cycles:
  - without REACTION_TIMEOUT_EN: counter holds 20, still GO.
  - with REACTION_TIMEOUT_EN: timeout=1, reaction_ms=20, single result_valid.
- Assert reset_n low mid-WAIT and mid-GO → all outputs 0 immediately. After release, start works normally.
